// File: rtl/rand_pkg.sv
// rtl/rand_pkg.sv - shared types, constants and mask helper for the bounded random path
package rand_pkg;

  // Width of the saturating rejection counter
  localparam int STAT_W = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  // IDLE: no sampling, FIFO may still drain. RUN: decimated sampling active.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Smallest 2^k-1 that is >= range_max, found by smearing the top set bit
  // down through every lower position; zero stays zero.
  function automatic logic [31:0] mask_for(input logic [31:0] range_max);
    logic [31:0] m;
    m = range_max;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    return m;
  endfunction

endpackage

// File: rtl/rand_fifo.sv
// rtl/rand_fifo.sv - small FIFO with registered head and push-while-full-with-pop support
module rand_fifo
  import rand_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   valid
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_next;
  logic          do_pop;
  logic          do_push;

  // A pop on empty is ignored; a push at full only lands when the head leaves in the same cycle
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign rd_next = rd_ptr + 1'b1;
  assign valid   = (count != '0);

  // Storage array: entries are written at the tail, never reset (contents are dead once count drops)
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  // Tail pointer advances on every accepted push; flush realigns it with the head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
    end else if (do_push) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Head pointer and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop) begin
        rd_ptr <= rd_next;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  // Registered head: load the incoming word when it becomes the head, else the next stored entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
    end else if (flush) begin
      dout <= '0;
    end else if (do_push && ((count == '0) || (do_pop && (count == ONE)))) begin
      dout <= din;
    end else if (do_pop && (count > ONE)) begin
      dout <= mem[rd_next];
    end else if (do_pop) begin
      dout <= '0;
    end
  end

endmodule

// File: rtl/rand_range.sv
// rtl/rand_range.sv - decimated LFSR sampler with mask-and-reject bounding and output FIFO
module rand_range
  import rand_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OUT_W = 8,
  parameter int DECIM = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       rnd,
  input  logic                   cfg_load,
  input  logic [OUT_W-1:0]       range_max,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [STAT_W-1:0]      stat_rej
);

  localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECIM - 1);

  state_t            state;
  state_t            state_nxt;
  logic [DCNT_W-1:0] dcnt;
  logic [OUT_W-1:0]  lim;
  logic [OUT_W-1:0]  mask;
  logic [OUT_W-1:0]  cand;
  logic              sample;
  logic              reject;
  logic              accept;
  logic [STAT_W-1:0] rej_q;
  logic              unused_rnd;

  // Only the low OUT_W bits feed a candidate; the rest of the LFSR word is intentionally ignored
  assign unused_rnd = ^rnd;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: cfg_load enters or restarts RUN; only rst brings the block back to IDLE
  always_comb begin
    state_nxt = state;
    if (cfg_load) begin
      state_nxt = RUN;
    end
  end

  // FSM outputs: sample strobe on the last decimation slot, then the bound test on the candidate
  always_comb begin
    sample = 1'b0;
    case (state)
      RUN:     sample = (dcnt == DCNT_LAST) && !cfg_load;
      default: sample = 1'b0;
    endcase
    cand   = rnd[OUT_W-1:0] & mask;
    reject = sample && (cand > lim);
    accept = sample && !(cand > lim);
  end

  // Decimation counter: cleared by cfg_load, free-runs 0..DECIM-1 while in RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt <= '0;
    end else if (cfg_load) begin
      dcnt <= '0;
    end else if (state == RUN) begin
      dcnt <= (dcnt == DCNT_LAST) ? '0 : dcnt + 1'b1;
    end
  end

  // Bound and mask are captured only on cfg_load so a changing range_max cannot skew a run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lim  <= '0;
      mask <= '0;
    end else if (cfg_load) begin
      lim  <= range_max;
      mask <= OUT_W'(mask_for(32'(range_max)));
    end
  end

  // Rejection statistic: cleared on cfg_load, counts out-of-range candidates, sticks at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rej_q <= '0;
    end else if (cfg_load) begin
      rej_q <= '0;
    end else if (reject && (rej_q != STAT_MAX)) begin
      rej_q <= rej_q + 1'b1;
    end
  end

  assign stat_rej = rej_q;

  // Accepted candidates are offered to the FIFO; it drops them itself when full without a pop
  rand_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (out_ready),
    .flush (cfg_load),
    .din   (cand),
    .dout  (out_data),
    .count (fifo_count),
    .valid (out_valid)
  );

endmodule

// File: tb/tb_rand_range.sv
// tb/tb_rand_range.sv - self-checking bench for rand_range with a queue-based reference model
module tb_rand_range;

  localparam int WIDTH = 16;
  localparam int OUT_W = 8;
  localparam int DECIM = 8;
  localparam int DEPTH = 4;

  logic                   clk;
  logic                   rst;
  logic [WIDTH-1:0]       rnd;
  logic                   cfg_load;
  logic [OUT_W-1:0]       range_max;
  logic [OUT_W-1:0]       out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [15:0]            stat_rej;

  int checks = 0;
  int passed = 0;

  // Reference model: run flag, cycles since last load, bound, mask, reject count, output queue
  bit m_run;
  int m_phase;
  int m_lim;
  int m_mask;
  int m_rej;
  int mq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rand_range #(
    .WIDTH (WIDTH),
    .OUT_W (OUT_W),
    .DECIM (DECIM),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rnd        (rnd),
    .cfg_load   (cfg_load),
    .range_max  (range_max),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_count (fifo_count),
    .stat_rej   (stat_rej)
  );

  function automatic int mask_of(int rm);
    int m;
    m = 0;
    while (m < rm) m = m * 2 + 1;
    return m;
  endfunction

  task automatic model_reset();
    m_run = 0;
    m_phase = 0;
    m_lim = 0;
    m_mask = 0;
    m_rej = 0;
    mq.delete();
  endtask

  // One clock: capture inputs, advance the model with the same edge, return 1ns after it
  task automatic tick();
    bit was_rst, ld, pop, smp, full;
    int rm, c;
    was_rst = rst;
    ld      = cfg_load;
    rm      = int'(range_max);
    pop     = out_ready && (mq.size() > 0);
    smp     = m_run && ((m_phase % DECIM) == DECIM - 1);
    c       = int'(rnd[OUT_W-1:0]) & m_mask;
    full    = (mq.size() == DEPTH);
    @(posedge clk);
    #1;
    if (was_rst) begin
      model_reset();
    end else if (ld) begin
      m_run = 1;
      m_phase = 0;
      m_lim = rm;
      m_mask = mask_of(rm);
      m_rej = 0;
      mq.delete();
    end else begin
      if (m_run) m_phase++;
      if (pop) void'(mq.pop_front());
      if (smp) begin
        if (c > m_lim) begin
          if (m_rej < 65535) m_rej++;
        end else if (!full || pop) begin
          mq.push_back(c);
        end
      end
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      rnd = WIDTH'($urandom);
      tick();
    end
  endtask

  task automatic load(int rm);
    cfg_load  = 1'b1;
    range_max = OUT_W'(rm);
    rnd       = WIDTH'($urandom);
    tick();
    cfg_load  = 1'b0;
  endtask

  // Called right after a load or a sample cycle: skips to the next sample cycle and drives lo there
  task automatic sample_at(logic [OUT_W-1:0] lo);
    idle(DECIM - 1);
    rnd = {(WIDTH-OUT_W)'($urandom), lo};
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_load = 1'b0;
    out_ready = 1'b0;
    range_max = '0;
    rnd = '0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", out_valid); else passed++;
    checks++; if (fifo_count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", fifo_count); else passed++;
    checks++; if (stat_rej !== 16'd0) $display("FAIL reset_stat: got %0d expected 0", stat_rej); else passed++;
    checks++; if (out_data !== 8'd0) $display("FAIL reset_data: got %0h expected 0", out_data); else passed++;
    for (int i = 0; i < 50; i++) begin
      out_ready = 1'($urandom);
      rnd = WIDTH'($urandom);
      tick();
      checks++;
      if (out_valid !== 1'b0 || fifo_count !== 3'd0 || stat_rej !== 16'd0)
        $display("FAIL idle_quiet: cycle %0d got valid=%0b count=%0d stat=%0d expected 0/0/0", i, out_valid, fifo_count, stat_rej);
      else passed++;
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    load(5);
    sample_at(8'h03);
    checks++; if (out_valid !== 1'b1) $display("FAIL basic_valid1: got %0b expected 1", out_valid); else passed++;
    checks++; if (out_data !== 8'h03) $display("FAIL basic_data1: got %0h expected 03", out_data); else passed++;
    checks++; if (stat_rej !== 16'd0) $display("FAIL basic_stat0: got %0d expected 0", stat_rej); else passed++;
    sample_at(8'h06);
    checks++; if (stat_rej !== 16'd1) $display("FAIL basic_reject: got %0d expected 1", stat_rej); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL basic_reject_valid: got %0b expected 0", out_valid); else passed++;
    sample_at(8'hF4);
    checks++; if (out_data !== 8'h04 || out_valid !== 1'b1) $display("FAIL basic_masked: got %0h/%0b expected 04/1", out_data, out_valid); else passed++;
    checks++; if (stat_rej !== 16'd1) $display("FAIL basic_stat1: got %0d expected 1", stat_rej); else passed++;
    idle(1);
  endtask

  task automatic test_full_drop();
    out_ready = 1'b0;
    load(255);
    for (int i = 1; i <= 5; i++) sample_at(OUT_W'(16 * i));
    checks++; if (fifo_count !== 3'd4) $display("FAIL full_count: got %0d expected 4", fifo_count); else passed++;
    checks++; if (stat_rej !== 16'd0) $display("FAIL full_stat: got %0d expected 0", stat_rej); else passed++;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== OUT_W'(16 * i))
        $display("FAIL full_drain: entry %0d got %0h/%0b expected %0h/1", i, out_data, out_valid, 16 * i);
      else passed++;
      rnd = WIDTH'($urandom);
      tick();
    end
    checks++; if (fifo_count !== 3'd0 || out_valid !== 1'b0) $display("FAIL full_empty: got %0d/%0b expected 0/0", fifo_count, out_valid); else passed++;
  endtask

  task automatic test_full_push_pop();
    logic [OUT_W-1:0] v [4];
    logic [OUT_W-1:0] exp_v;
    out_ready = 1'b0;
    load(255);
    for (int i = 0; i < 4; i++) begin
      v[i] = OUT_W'($urandom);
      sample_at(v[i]);
    end
    idle(DECIM - 1);
    rnd = {(WIDTH-OUT_W)'($urandom), 8'h77};
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (fifo_count !== 3'd4) $display("FAIL pushpop_count: got %0d expected 4", fifo_count); else passed++;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      exp_v = (i == 4) ? 8'h77 : v[i];
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_v)
        $display("FAIL pushpop_order: entry %0d got %0h/%0b expected %0h/1", i, out_data, out_valid, exp_v);
      else passed++;
      rnd = WIDTH'($urandom);
      tick();
    end
  endtask

  task automatic test_zero_range();
    int delivered;
    delivered = 0;
    out_ready = 1'b1;
    load(0);
    repeat (200) begin
      rnd = WIDTH'($urandom);
      tick();
      if (out_valid === 1'b1) begin
        delivered++;
        checks++; if (out_data !== 8'd0) $display("FAIL zero_value: got %0h expected 0", out_data); else passed++;
      end
    end
    checks++; if (delivered !== 25) $display("FAIL zero_delivered: got %0d expected 25", delivered); else passed++;
    checks++; if (stat_rej !== 16'd0) $display("FAIL zero_stat: got %0d expected 0", stat_rej); else passed++;
  endtask

  task automatic test_reload_mid_run();
    out_ready = 1'b0;
    load(2);
    repeat (9) sample_at(8'h03);
    repeat (3) sample_at(8'h01);
    checks++; if (fifo_count !== 3'd3) $display("FAIL reload_pre_count: got %0d expected 3", fifo_count); else passed++;
    checks++; if (stat_rej !== 16'd9) $display("FAIL reload_pre_stat: got %0d expected 9", stat_rej); else passed++;
    out_ready = 1'b1;
    load(255);
    checks++; if (fifo_count !== 3'd0 || out_valid !== 1'b0) $display("FAIL reload_flush: got %0d/%0b expected 0/0", fifo_count, out_valid); else passed++;
    checks++; if (stat_rej !== 16'd0) $display("FAIL reload_stat: got %0d expected 0", stat_rej); else passed++;
    idle(DECIM - 1);
    checks++; if (out_valid !== 1'b0) $display("FAIL reload_early: got %0b expected 0", out_valid); else passed++;
    rnd = {(WIDTH-OUT_W)'($urandom), 8'hAB};
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hAB) $display("FAIL reload_first: got %0h/%0b expected ab/1", out_data, out_valid); else passed++;
    idle(DECIM - 1);
    rnd = {(WIDTH-OUT_W)'($urandom), 8'h5A};
    cfg_load = 1'b1;
    range_max = 8'hFF;
    tick();
    cfg_load = 1'b0;
    checks++; if (fifo_count !== 3'd0) $display("FAIL load_beats_sample: got %0d expected 0", fifo_count); else passed++;
  endtask

  task automatic test_rst_mid_burst();
    int bad;
    out_ready = 1'b0;
    load(2);
    sample_at(8'h03);
    sample_at(8'h02);
    sample_at(8'h01);
    checks++; if (fifo_count !== 3'd2 || stat_rej !== 16'd1) $display("FAIL rst_pre: got %0d/%0d expected 2/1", fifo_count, stat_rej); else passed++;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_async_valid: got %0b expected 0", out_valid); else passed++;
    checks++; if (out_data !== 8'd0) $display("FAIL rst_async_data: got %0h expected 0", out_data); else passed++;
    checks++; if (fifo_count !== 3'd0) $display("FAIL rst_async_count: got %0d expected 0", fifo_count); else passed++;
    checks++; if (stat_rej !== 16'd0) $display("FAIL rst_async_stat: got %0d expected 0", stat_rej); else passed++;
    tick();
    tick();
    rst = 1'b0;
    bad = 0;
    repeat (30) begin
      out_ready = 1'($urandom);
      rnd = WIDTH'($urandom);
      tick();
      if (out_valid !== 1'b0 || fifo_count !== 3'd0) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL rst_needs_load: got %0d active cycles expected 0", bad); else passed++;
  endtask

  task automatic test_random();
    int ready_pct;
    int rm;
    ready_pct = 50;
    for (int cyc = 0; cyc < 2400; cyc++) begin
      if (cyc % 150 == 0) ready_pct = $urandom_range(0, 100);
      if (cyc == 0 || $urandom_range(0, 79) == 0) begin
        case ($urandom_range(0, 3))
          0:       rm = $urandom_range(0, 7);
          1:       rm = $urandom_range(0, 255);
          2:       rm = 255;
          default: rm = $urandom_range(128, 255);
        endcase
        cfg_load = 1'b1;
        range_max = OUT_W'(rm);
      end
      out_ready = ($urandom_range(1, 100) <= ready_pct);
      rnd = WIDTH'($urandom);
      tick();
      cfg_load = 1'b0;
      checks++; if (out_valid !== (mq.size() != 0)) $display("FAIL rand_valid: cycle %0d got %0b expected %0b", cyc, out_valid, mq.size() != 0); else passed++;
      checks++; if (int'(fifo_count) !== mq.size()) $display("FAIL rand_count: cycle %0d got %0d expected %0d", cyc, fifo_count, mq.size()); else passed++;
      checks++; if (int'(stat_rej) !== m_rej) $display("FAIL rand_stat: cycle %0d got %0d expected %0d", cyc, stat_rej, m_rej); else passed++;
      if (mq.size() != 0) begin
        checks++; if (int'(out_data) !== mq[0]) $display("FAIL rand_data: cycle %0d got %0h expected %0h", cyc, out_data, mq[0]); else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_drop();
    test_full_push_pop();
    test_zero_range();
    test_reload_mid_run();
    test_rst_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/rand_range.md
# rand_range

Downstream consumer of the free-running LFSR in the random-number path. Samples the LFSR word at a decimated rate, reduces it to an unbiased value in 0..range_max by mask-and-reject, and buffers accepted values in a small FIFO with a valid/ready output. Game logic draws bounded random numbers from here instead of slicing raw LFSR state.

## Interface
- WIDTH, 16: width of the incoming LFSR word.
- OUT_W, 8: output value width; OUT_W <= WIDTH.
- DECIM, 8: cycles between samples; must be >= OUT_W so successive candidates share no shifted bits.
- DEPTH, 4: FIFO entries; power of two, >= 2.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- rnd  in  WIDTH  LFSR output, one new value per clk.
- cfg_load  in  1  single-cycle pulse; latch range_max, flush FIFO, (re)start sampling.
- range_max  in  OUT_W  inclusive upper bound of output values; sampled only on cfg_load.
- out_data  out  OUT_W  head-of-FIFO value.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data when out_valid & out_ready.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- stat_rej  out  16  saturating count of rejected candidates since last cfg_load.

## Operation
- States: IDLE (reset; no sampling; FIFO may still drain), RUN.
- IDLE -> RUN on cfg_load. RUN -> RUN on cfg_load (restart). Only rst returns to IDLE.
- On cfg_load: lim <= range_max; mask <= smallest 2^k-1 >= range_max (range_max=0 -> mask=0); dcnt <= 0; FIFO flushed (count 0, out_valid 0 next cycle); stat_rej <= 0.
- In RUN, dcnt counts 0..DECIM-1 and wraps. Sample cycle: dcnt == DECIM-1.
- Candidate c = rnd[OUT_W-1:0] & mask, all unsigned, OUT_W bits.
- On sample cycle: if c > lim -> rejected, stat_rej += 1 (saturates at 16'hFFFF). Else if FIFO has room -> push c. Else (full, no pop this cycle) -> sample dropped, not counted as rejection.
- Room = count < DEPTH, or count == DEPTH with a pop in the same cycle (simultaneous push/pop at full permitted; count unchanged).
- Pop when out_valid & out_ready; pop on empty is ignored.
- cfg_load coincident with a sample cycle: cfg_load wins, sample discarded. cfg_load coincident with a pop: flush wins.
- range_max = 2^OUT_W-1: mask all ones, no rejections possible.

## Timing
- Reset values: out_data 0, out_valid 0, fifo_count 0, stat_rej 0, state IDLE, dcnt 0, lim 0, mask 0.
- cfg_load at edge t -> RUN from t+1 with dcnt 0; first sample cycle is t+DECIM; pushed value visible on out_data/out_valid at t+DECIM+1.
- Push-to-visible latency 1 cycle; out_data is registered head-of-FIFO, stable while out_valid & !out_ready.
- Pop at edge t -> next entry (or out_valid 0) at t+1. Sustained throughput at most one accept per DECIM cycles.
- fifo_count and stat_rej update on the same edge as the push/reject.
- rst mid-operation: all state to reset values immediately; FIFO contents lost; requires a new cfg_load.

## Structure
- Package rand_pkg: function mask_for(range_max) (ceil-to-2^k-1), stat counter width constant (16), state enum {IDLE, RUN}.
- Sub-module rand_fifo (params W, DEPTH; push, pop, flush, dout, count, valid), registered output, full-with-pop push support. Top holds FSM, decimation counter, mask/compare, stat counter.

## Test plan
- Reset then run 50 cycles with no cfg_load, rnd random -> out_valid 0, fifo_count 0, stat_rej 0 throughout.
- cfg_load at t with range_max=8'd5 (mask 7); rnd low byte 0x03 at t+8, 0x06 at t+16, 0xF4 at t+24; out_ready=1 -> 3 out at t+9, stat_rej=1 at t+17, 4 (0xF4&7) out at t+25.
- range_max=8'hFF, out_ready=0, rnd low byte = 0x10,0x20,0x30,0x40,0x50 on 5 successive sample cycles -> fifo_count 4, 0x50 dropped, stat_rej 0; then out_ready=1 -> 0x10,0x20,0x30,0x40 in order.
- FIFO full (4), out_ready=1 exactly on a sample cycle with candidate 0x77 -> head popped, 0x77 pushed, fifo_count stays 4.
- range_max=0, random rnd for 200 cycles, out_ready=1 -> every output 0, stat_rej 0, 25 values delivered.
- cfg_load mid-run with fifo_count 3 and stat_rej 9 -> next cycle fifo_count 0, out_valid 0, stat_rej 0; first new sample DECIM cycles after cfg_load; rst asserted later mid-burst -> all outputs 0 same cycle.
